// File: rtl/fb_pkg.sv
// ============================================================================
// Module      : fb_pkg
// Description : Shared constants for the framebuffer write scheduler.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package fb_pkg;

    localparam int DEF_SCREEN_WIDTH  = 640;
    localparam int DEF_SCREEN_HEIGHT = 480;

    localparam int PLOT = 0;
    localparam int OVL  = 1;

    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] ST_CLEAR     = 3'b001;
    localparam logic [STATE_W-1:0] ST_DRAW      = 3'b010;
    localparam logic [STATE_W-1:0] ST_WAIT_SWAP = 3'b100;

endpackage

`default_nettype wire

// File: rtl/fb_rr_arb2.sv
// ============================================================================
// Module      : fb_rr_arb2
// Description : Two-input round-robin arbiter, combinational grant, registered
//               last-winner flag.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fb_rr_arb2
    import fb_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    logic r_last_ovl;

    always_comb begin
        o_gnt = 2'b00;
        if (i_en) begin
            if (i_req[PLOT] && i_req[OVL]) begin
                if (r_last_ovl) o_gnt[PLOT] = 1'b1;
                else            o_gnt[OVL]  = 1'b1;
            end else begin
                o_gnt = i_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn)            r_last_ovl <= 1'b1;
        else if (o_gnt != 2'b00) r_last_ovl <= o_gnt[OVL];
    end

endmodule

`default_nettype wire

// File: rtl/fb_write_scheduler.sv
// ============================================================================
// Module      : fb_write_scheduler
// Description : Owns the framebuffer write port: clears the back buffer,
//               arbitrates plotter/overlay writes and swaps buffers.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fb_write_scheduler
    import fb_pkg::*;
#(
    parameter int SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
    parameter int ADDR_WIDTH    = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT),
    parameter int DROP_WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  i_frame_start,
    input  logic                  i_plot_req,
    input  logic [ADDR_WIDTH-1:0] i_plot_addr,
    input  logic                  i_plot_data,
    output logic                  o_plot_gnt,
    input  logic                  i_plot_frame_done,
    input  logic                  i_ovl_req,
    input  logic [ADDR_WIDTH-1:0] i_ovl_addr,
    input  logic                  i_ovl_data,
    output logic                  o_ovl_gnt,
    output logic [ADDR_WIDTH-1:0] o_fb_addr,
    output logic                  o_fb_data,
    output logic                  o_fb_wr_en,
    output logic                  o_fb_wr_buf,
    output logic                  o_fb_disp_buf,
    output logic                  o_clearing,
    output logic                  o_addr_err,
    output logic [DROP_WIDTH-1:0] o_drop_count
);

    localparam int unsigned c_npix = SCREEN_WIDTH * SCREEN_HEIGHT;
    localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(c_npix - 1);

    logic [STATE_W-1:0]    r_state;
    logic [STATE_W-1:0]    w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_clear_addr;
    logic                  r_wr_buf;
    logic [ADDR_WIDTH-1:0] r_fb_addr;
    logic                  r_fb_data;
    logic                  r_fb_wr_en;
    logic                  r_clearing;
    logic                  r_addr_err;
    logic [DROP_WIDTH-1:0] r_drop;

    logic                  w_in_clear;
    logic                  w_arb_en;
    logic                  w_swap;
    logic                  w_drop;
    logic [1:0]            w_gnt;
    logic                  w_any_gnt;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic                  w_sel_data;
    logic                  w_oob;

    fb_rr_arb2 u_arb (
        .clk    (clk),
        .resetn (resetn),
        .i_en   (w_arb_en),
        .i_req  ({i_ovl_req, i_plot_req}),
        .o_gnt  (w_gnt)
    );

    always_ff @(posedge clk) begin
        if (!resetn) r_state <= ST_CLEAR;
        else         r_state <= w_state_nxt;
    end

    // A frame_start arriving together with done counts as a completed frame.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR:     if (r_clear_addr == c_last_addr) w_state_nxt = ST_DRAW;
            ST_DRAW:      if (i_plot_frame_done)
                              w_state_nxt = i_frame_start ? ST_CLEAR : ST_WAIT_SWAP;
            ST_WAIT_SWAP: if (i_frame_start) w_state_nxt = ST_CLEAR;
            default:      w_state_nxt = ST_CLEAR;
        endcase
    end

    always_comb begin
        w_in_clear = (r_state == ST_CLEAR);
        w_arb_en   = (r_state == ST_DRAW) && resetn;
        w_swap     = i_frame_start && ((r_state == ST_WAIT_SWAP) ||
                                       ((r_state == ST_DRAW) && i_plot_frame_done));
        w_drop     = i_frame_start && (w_in_clear ||
                                       ((r_state == ST_DRAW) && !i_plot_frame_done));
    end

    assign o_plot_gnt = w_gnt[PLOT];
    assign o_ovl_gnt  = w_gnt[OVL];
    assign w_any_gnt  = |w_gnt;
    assign w_sel_addr = w_gnt[OVL] ? i_ovl_addr : i_plot_addr;
    assign w_sel_data = w_gnt[OVL] ? i_ovl_data : i_plot_data;
    assign w_oob      = 32'(w_sel_addr) >= c_npix;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_clear_addr <= '0;
            r_wr_buf     <= 1'b0;
            r_fb_addr    <= '0;
            r_fb_data    <= 1'b0;
            r_fb_wr_en   <= 1'b0;
            r_clearing   <= 1'b1;
            r_addr_err   <= 1'b0;
            r_drop       <= '0;
        end else begin
            r_clearing <= (w_state_nxt == ST_CLEAR);
            if (w_swap) r_wr_buf <= ~r_wr_buf;
            if (w_drop && (r_drop != {DROP_WIDTH{1'b1}})) r_drop <= r_drop + 1'b1;

            if (w_in_clear) begin
                r_clear_addr <= (r_clear_addr == c_last_addr) ? '0
                                : r_clear_addr + ADDR_WIDTH'(1);
                r_fb_addr    <= r_clear_addr;
                r_fb_data    <= 1'b0;
                r_fb_wr_en   <= 1'b1;
            end else if (w_any_gnt) begin
                // Out-of-range writes are still granted so the requester advances.
                r_fb_addr    <= w_sel_addr;
                r_fb_data    <= w_sel_data;
                r_fb_wr_en   <= !w_oob;
                if (w_oob) r_addr_err <= 1'b1;
            end else begin
                r_fb_wr_en   <= 1'b0;
            end
        end
    end

    assign o_fb_addr     = r_fb_addr;
    assign o_fb_data     = r_fb_data;
    assign o_fb_wr_en    = r_fb_wr_en;
    assign o_fb_wr_buf   = r_wr_buf;
    assign o_fb_disp_buf = ~r_wr_buf;
    assign o_clearing    = r_clearing;
    assign o_addr_err    = r_addr_err;
    assign o_drop_count  = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_fb_write_scheduler.sv
// ============================================================================
// Module      : tb_fb_write_scheduler
// Description : Directed self-checking bench for fb_write_scheduler (8x4).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_fb_write_scheduler;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int AW = 6;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          fs = 1'b0;
    logic          done = 1'b0;
    logic          preq = 1'b0, pdata = 1'b0, oreq = 1'b0, odata = 1'b0;
    logic [AW-1:0] paddr = '0, oaddr = '0;
    logic          pgnt, ognt, wr_en, wr_buf, disp_buf, clearing, addr_err, fb_data;
    logic [AW-1:0] fb_addr;
    logic [DW-1:0] drop;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fb_write_scheduler #(
        .SCREEN_WIDTH (W),
        .SCREEN_HEIGHT(H),
        .ADDR_WIDTH   (AW),
        .DROP_WIDTH   (DW)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .i_frame_start    (fs),
        .i_plot_req       (preq),
        .i_plot_addr      (paddr),
        .i_plot_data      (pdata),
        .o_plot_gnt       (pgnt),
        .i_plot_frame_done(done),
        .i_ovl_req        (oreq),
        .i_ovl_addr       (oaddr),
        .i_ovl_data       (odata),
        .o_ovl_gnt        (ognt),
        .o_fb_addr        (fb_addr),
        .o_fb_data        (fb_data),
        .o_fb_wr_en       (wr_en),
        .o_fb_wr_buf      (wr_buf),
        .o_fb_disp_buf    (disp_buf),
        .o_clearing       (clearing),
        .o_addr_err       (addr_err),
        .o_drop_count     (drop)
    );

    typedef struct {
        logic          preq;
        logic [AW-1:0] paddr;
        logic          pdata;
        logic          oreq;
        logic [AW-1:0] oaddr;
        logic          odata;
        logic          fs;
        logic          done;
        logic [1:0]    gnt;     // {ovl, plot}, same cycle
        logic          en;      // registered outputs, next cycle
        logic [AW-1:0] addr;
        logic          data;
        logic          wbuf;
        logic          clr;
        logic          err;
        logic [DW-1:0] drop;
    } vec_t;

    vec_t tbl[11];

    function automatic vec_t mk(input int pr, input int pa, input int pd,
                                input int orq, input int oa, input int od,
                                input int f, input int d, input int g,
                                input int e, input int a, input int dt,
                                input int dp);
        vec_t v;
        v.preq = 1'(pr);  v.paddr = AW'(pa); v.pdata = 1'(pd);
        v.oreq = 1'(orq); v.oaddr = AW'(oa); v.odata = 1'(od);
        v.fs = 1'(f); v.done = 1'(d); v.gnt = 2'(g);
        v.en = 1'(e); v.addr = AW'(a); v.data = 1'(dt);
        v.wbuf = 1'b0; v.clr = 1'b0; v.err = 1'b0; v.drop = DW'(dp);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Called on the negedge before the first clear issue edge.
    task automatic check_clear(input logic exp_buf);
        for (int i = 0; i < W * H; i++) begin
            @(negedge clk);
            chk("clear_en", 32'(wr_en), 1);
            chk("clear_addr", 32'(fb_addr), i);
            chk("clear_data", 32'(fb_data), 0);
            chk("clear_buf", 32'(wr_buf), 32'(exp_buf));
            chk("clearing", 32'(clearing), (i < W * H - 1) ? 1 : 0);
            if (i < W * H - 1) chk("clear_gnt", 32'({ognt, pgnt}), 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic       exp_last_ovl;
        logic [1:0] exp_g;

        tbl[0]  = mk(1, 5, 1, 1, 9, 0, 0, 0, 2'b01, 1, 5, 1, 0);
        tbl[1]  = mk(1, 5, 1, 1, 9, 0, 0, 0, 2'b10, 1, 9, 0, 0);
        tbl[2]  = mk(1, 5, 1, 1, 9, 0, 0, 0, 2'b01, 1, 5, 1, 0);
        tbl[3]  = mk(1, 5, 1, 1, 9, 0, 0, 0, 2'b10, 1, 9, 0, 0);
        tbl[4]  = mk(0, 5, 1, 0, 9, 0, 0, 0, 2'b00, 0, 9, 0, 0);
        tbl[5]  = mk(0, 5, 1, 1, 9, 0, 0, 0, 2'b10, 1, 9, 0, 0);
        tbl[6]  = mk(1, 5, 1, 1, 9, 0, 0, 0, 2'b01, 1, 5, 1, 0);
        tbl[7]  = mk(1, 5, 1, 0, 9, 0, 0, 0, 2'b01, 1, 5, 1, 0);
        tbl[8]  = mk(1, 5, 1, 1, 9, 0, 1, 0, 2'b10, 1, 9, 0, 1);
        tbl[9]  = mk(1, 5, 1, 1, 9, 0, 0, 0, 2'b01, 1, 5, 1, 1);
        tbl[10] = mk(0, 5, 1, 0, 9, 0, 0, 1, 2'b00, 0, 5, 1, 1);

        // Reset with both requests asserted: no grants, reset values.
        preq = 1'b1; paddr = 6'd5; pdata = 1'b1;
        oreq = 1'b1; oaddr = 6'd9; odata = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'({ognt, pgnt}), 0);
        chk("rst_en", 32'(wr_en), 0);
        chk("rst_addr", 32'(fb_addr), 0);
        chk("rst_bufs", 32'({wr_buf, disp_buf}), 32'b01);
        chk("rst_clearing", 32'(clearing), 1);
        chk("rst_err_drop", 32'({addr_err, drop}), 0);

        resetn = 1'b1;
        check_clear(1'b0);

        // DRAW vectors: round-robin, single requesters, drop without swap, done.
        for (int i = 0; i < 11; i++) begin
            preq = tbl[i].preq; paddr = tbl[i].paddr; pdata = tbl[i].pdata;
            oreq = tbl[i].oreq; oaddr = tbl[i].oaddr; odata = tbl[i].odata;
            fs = tbl[i].fs; done = tbl[i].done;
            #1;
            chk($sformatf("v%0d_gnt", i), 32'({ognt, pgnt}), 32'(tbl[i].gnt));
            @(negedge clk);
            chk($sformatf("v%0d_en", i), 32'(wr_en), 32'(tbl[i].en));
            chk($sformatf("v%0d_addr", i), 32'(fb_addr), 32'(tbl[i].addr));
            chk($sformatf("v%0d_data", i), 32'(fb_data), 32'(tbl[i].data));
            chk($sformatf("v%0d_buf", i), 32'(wr_buf), 32'(tbl[i].wbuf));
            chk($sformatf("v%0d_clr", i), 32'(clearing), 32'(tbl[i].clr));
            chk($sformatf("v%0d_err", i), 32'(addr_err), 32'(tbl[i].err));
            chk($sformatf("v%0d_drop", i), 32'(drop), 32'(tbl[i].drop));
        end

        // WAIT_SWAP: no grants for 9 cycles, a stray done is ignored, then swap.
        preq = 1'b1; oreq = 1'b1; fs = 1'b0; done = 1'b0;
        for (int i = 0; i < 9; i++) begin
            done = (i == 3);
            #1;
            chk("wait_gnt", 32'({ognt, pgnt}), 0);
            @(negedge clk);
            chk("wait_en", 32'(wr_en), 0);
            chk("wait_state", 32'({clearing, wr_buf}), 0);
        end
        done = 1'b0; fs = 1'b1;
        #1;
        chk("swap_gnt", 32'({ognt, pgnt}), 0);
        @(negedge clk);
        fs = 1'b0;
        chk("swap_bufs", 32'({wr_buf, disp_buf}), 32'b10);
        chk("swap_clearing", 32'(clearing), 1);
        chk("swap_en", 32'(wr_en), 0);
        chk("swap_drop", 32'(drop), 1);
        check_clear(1'b1);

        // done and frame_start together in DRAW: grant, swap, no drop.
        fs = 1'b1; done = 1'b1;
        #1;
        chk("same_gnt", 32'({ognt, pgnt}), 32'b10);
        @(negedge clk);
        fs = 1'b0; done = 1'b0;
        chk("same_wr", 32'({wr_en, fb_addr}), 32'({1'b1, 6'd9}));
        chk("same_bufs", 32'({wr_buf, disp_buf}), 32'b01);
        chk("same_clearing", 32'(clearing), 1);
        chk("same_drop", 32'(drop), 1);
        check_clear(1'b0);

        // Repeated frame_start in DRAW: drop saturates, grants keep alternating.
        exp_last_ovl = 1'b1;
        for (int k = 1; k <= 259; k++) begin
            fs = 1'b1;
            #1;
            exp_g = exp_last_ovl ? 2'b01 : 2'b10;
            chk("sat_gnt", 32'({ognt, pgnt}), 32'(exp_g));
            exp_last_ovl = exp_g[1];
            @(negedge clk);
            if (k == 5)   chk("drop_6", 32'(drop), 6);
            if (k == 254) chk("drop_255", 32'(drop), 255);
        end
        fs = 1'b0;
        chk("drop_sat", 32'(drop), 255);
        chk("sat_no_swap", 32'({wr_buf, clearing}), 0);

        // Out-of-range address: granted, not written, sticky error.
        oreq = 1'b0; paddr = 6'd40;
        #1;
        chk("oob_gnt", 32'({ognt, pgnt}), 32'b01);
        @(negedge clk);
        chk("oob_en", 32'(wr_en), 0);
        chk("oob_err", 32'(addr_err), 1);
        paddr = 6'd5;
        #1;
        chk("ok_gnt", 32'({ognt, pgnt}), 32'b01);
        @(negedge clk);
        chk("ok_wr", 32'({wr_en, fb_addr}), 32'({1'b1, 6'd5}));
        chk("err_sticky", 32'(addr_err), 1);

        // Enter a new clear, then reset partway through it.
        preq = 1'b0; done = 1'b1;
        @(negedge clk);
        done = 1'b0; fs = 1'b1;
        @(negedge clk);
        fs = 1'b0;
        chk("pre_rst_buf", 32'(wr_buf), 1);
        chk("pre_rst_drop", 32'(drop), 255);
        repeat (3) @(negedge clk);
        chk("midclear_addr", 32'({wr_en, fb_addr}), 32'({1'b1, 6'd2}));
        preq = 1'b1; oreq = 1'b1; resetn = 1'b0;
        #1;
        chk("midrst_gnt", 32'({ognt, pgnt}), 0);
        @(negedge clk);
        chk("midrst_out", 32'({wr_en, fb_addr}), 0);
        chk("midrst_bufs", 32'({wr_buf, disp_buf}), 32'b01);
        chk("midrst_err_drop", 32'({addr_err, drop}), 0);
        chk("midrst_clearing", 32'(clearing), 1);
        resetn = 1'b1;
        check_clear(1'b0);
        #1;
        chk("post_rst_gnt", 32'({ognt, pgnt}), 32'b01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
